// File: rtl/pipe_stage_chain.sv
// Elastic pipeline-register chain: per-stage valid, stall, flush and ready/valid
// backpressure. Stage 0 is youngest, stage STAGES-1 presents to the consumer.

module pipe_stage_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              enable,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              clr,
    output logic              valid_q,
    output logic [DATA_W-1:0] data_q
);

    // A load beats a clear: a flushed or emptied stage may refill in the same cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (enable) begin
            if (load) begin
                valid_q <= 1'b1;
                data_q  <= load_data;
            end else if (clr) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

module pipe_stage_chain #(
    parameter int DATA_W = 32,
    parameter int STAGES = 5,
    parameter int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic [STAGES-1:0]        stall,
    input  logic [STAGES-1:0]        flush,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*DATA_W-1:0] stage_data,
    output logic [CNT_W-1:0]         occupancy
);

    logic [STAGES-1:0]             valid_q;
    logic [STAGES-1:0][DATA_W-1:0] data_q;
    logic [STAGES-1:0][DATA_W-1:0] load_data;
    logic [STAGES-1:0]             v;
    logic [STAGES-1:0]             acc;
    logic [STAGES-1:0]             adv;
    logic [STAGES-1:0]             load;
    logic [STAGES-1:0]             clr;
    logic                          in_hs;

    assign v = valid_q & ~flush;

    // Ready ripples from the oldest stage down; each stage's taker is the accept
    // of the stage above it, with the consumer acting as taker for the top.
    always_comb begin
        logic taker;
        acc   = '0;
        adv   = '0;
        taker = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc[i] = ~stall[i] & (~v[i] | taker);
            adv[i] = v[i] & ~stall[i] & taker;
            taker  = acc[i];
        end
    end

    assign in_ready  = enable & acc[0];
    assign in_hs     = in_valid & in_ready;
    assign out_valid = enable & v[STAGES-1] & ~stall[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    assign load = {adv[STAGES-2:0], in_hs};
    assign clr  = adv | flush;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign load_data[g] = in_data;
        end else begin : g_body
            assign load_data[g] = data_q[g-1];
        end

        pipe_stage_cell #(
            .DATA_W(DATA_W)
        ) u_cell (
            .clk      (clk),
            .srst     (srst),
            .enable   (enable),
            .load     (load[g]),
            .load_data(load_data[g]),
            .clr      (clr[g]),
            .valid_q  (valid_q[g]),
            .data_q   (data_q[g])
        );
    end

    assign stage_valid = valid_q;
    assign stage_data  = data_q;

    // Counts registered valids only, so stall/flush never reach this output.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + CNT_W'(valid_q[i]);
        end
    end

endmodule
